tmds_multich_encoder: RTL and testbench

- Parametrised N-channel TMDS/HDMI symbol encoder. Successor to the single-channel DVI encoder.
- Adds per-channel period modes: control, video (8b/10b with DC balance), TERC4 data-island, and two guard-band codes.
- Adds an optional extra output register stage, an output-valid flag and a visible running-disparity output.
- Sits between the video/packet timing generator and the 10:1 serializers.

---
 rtl/tmds_multich_encoder.sv | 220 ++++++++++++++++++++++
 tb/tb_tmds_multich_encoder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_multich_encoder.sv
// N-channel TMDS symbol encoder: per-channel control, 8b/10b video with DC
// balance, TERC4 data-island and guard-band codes, two or three cycle latency.

module tmds_lane #(
    parameter int EXTRA_PIPE = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] mode,
    input  logic [1:0] c,
    input  logic [7:0] d,
    input  logic [3:0] aux,
    output logic [9:0] q,
    output logic [4:0] disp
);
    localparam logic [2:0] MODE_CTRL    = 3'd0;
    localparam logic [2:0] MODE_VIDEO   = 3'd1;
    localparam logic [2:0] MODE_TERC4   = 3'd2;
    localparam logic [2:0] MODE_GUARD_A = 3'd3;
    localparam logic [2:0] MODE_GUARD_B = 3'd4;
    localparam logic [9:0] SYM_CTRL0    = 10'b1101010100;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int k = 0; k < 8; k++) n = n + {3'b000, v[k]};
        return n;
    endfunction

    // Transition-minimising stage: XNOR chain for dense bytes, XOR otherwise.
    function automatic logic [8:0] minimise(input logic [7:0] v);
        logic [3:0] n;
        logic       xn;
        logic [8:0] m;
        n    = ones8(v);
        xn   = (n > 4'd4) || ((n == 4'd4) && !v[0]);
        m    = '0;
        m[0] = v[0];
        for (int k = 1; k < 8; k++) m[k] = xn ? ~(m[k-1] ^ v[k]) : (m[k-1] ^ v[k]);
        m[8] = ~xn;
        return m;
    endfunction

    function automatic logic [9:0] terc4(input logic [3:0] a);
        logic [9:0] s;
        case (a)
            4'h0: s = 10'b1010011100;
            4'h1: s = 10'b1001100011;
            4'h2: s = 10'b1011100100;
            4'h3: s = 10'b1011100010;
            4'h4: s = 10'b0101110001;
            4'h5: s = 10'b0100011110;
            4'h6: s = 10'b0110001110;
            4'h7: s = 10'b0100111100;
            4'h8: s = 10'b1011001100;
            4'h9: s = 10'b0100111001;
            4'hA: s = 10'b0110011100;
            4'hB: s = 10'b1011000110;
            4'hC: s = 10'b1010001110;
            4'hD: s = 10'b1001110001;
            4'hE: s = 10'b0101100011;
            default: s = 10'b1011000011;
        endcase
        return s;
    endfunction

    function automatic logic [9:0] ctrl_sym(input logic [1:0] cc);
        logic [9:0] s;
        case (cc)
            2'b00:   s = 10'b1101010100;
            2'b01:   s = 10'b0010101011;
            2'b10:   s = 10'b0101010100;
            default: s = 10'b1010101011;
        endcase
        return s;
    endfunction

    // Stage 1
    logic [8:0] qm_s1;
    logic [2:0] mode_s1;
    logic [1:0] c_s1;
    logic [3:0] aux_s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qm_s1   <= '0;
            mode_s1 <= MODE_CTRL;
            c_s1    <= '0;
            aux_s1  <= '0;
        end else begin
            qm_s1   <= minimise(d);
            mode_s1 <= mode;
            c_s1    <= c;
            aux_s1  <= aux;
        end
    end

    // Stage 2: symbol select and disparity update, all in 5-bit modular arithmetic
    logic [3:0] n_s1;
    logic [4:0] two_n, qm8_x2, cnt, cnt_nx;
    logic       cnt_pos, cnt_neg;
    logic [9:0] q_nx, q_s2;

    always_comb begin
        n_s1    = ones8(qm_s1[7:0]);
        two_n   = {n_s1, 1'b0};
        qm8_x2  = {3'b000, qm_s1[8], 1'b0};
        cnt_pos = !cnt[4] && (cnt != 5'd0);
        cnt_neg = cnt[4];
        q_nx    = ctrl_sym(c_s1);
        cnt_nx  = '0;
        case (mode_s1)
            MODE_VIDEO: begin
                if ((cnt == 5'd0) || (n_s1 == 4'd4)) begin
                    q_nx   = {~qm_s1[8], qm_s1[8], qm_s1[8] ? qm_s1[7:0] : ~qm_s1[7:0]};
                    cnt_nx = qm_s1[8] ? (cnt + two_n - 5'd8) : (cnt + 5'd8 - two_n);
                end else if ((cnt_pos && (n_s1 > 4'd4)) || (cnt_neg && (n_s1 < 4'd4))) begin
                    q_nx   = {1'b1, qm_s1[8], ~qm_s1[7:0]};
                    cnt_nx = cnt + qm8_x2 + 5'd8 - two_n;
                end else begin
                    q_nx   = {1'b0, qm_s1[8], qm_s1[7:0]};
                    cnt_nx = cnt + two_n - 5'd8 - (5'd2 - qm8_x2);
                end
            end
            MODE_TERC4:   q_nx = terc4(aux_s1);
            MODE_GUARD_A: q_nx = 10'b0100110011;
            MODE_GUARD_B: q_nx = 10'b1011001100;
            default:      q_nx = ctrl_sym(c_s1);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_s2 <= SYM_CTRL0;
            cnt  <= '0;
        end else begin
            q_s2 <= q_nx;
            cnt  <= cnt_nx;
        end
    end

    generate
        if (EXTRA_PIPE != 0) begin : g_xp
            logic [9:0] q_s3;
            logic [4:0] disp_s3;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_s3    <= SYM_CTRL0;
                    disp_s3 <= '0;
                end else begin
                    q_s3    <= q_s2;
                    disp_s3 <= cnt;
                end
            end
            assign q    = q_s3;
            assign disp = disp_s3;
        end else begin : g_nxp
            assign q    = q_s2;
            assign disp = cnt;
        end
    endgenerate

endmodule

module tmds_multich_encoder #(
    parameter int NUM_CH     = 3,
    parameter int EXTRA_PIPE = 0
) (
    input  logic                  CK,
    input  logic                  RESET,
    input  logic [3*NUM_CH-1:0]   MODE,
    input  logic [2*NUM_CH-1:0]   C,
    input  logic [8*NUM_CH-1:0]   D,
    input  logic [4*NUM_CH-1:0]   AUX,
    output logic [10*NUM_CH-1:0]  Q,
    output logic                  Q_VALID,
    output logic [5*NUM_CH-1:0]   DISP
);
    localparam int STAGES = (EXTRA_PIPE != 0) ? 2 : 1;

    logic [NUM_CH-1:0][2:0] mode_v;
    logic [NUM_CH-1:0][1:0] c_v;
    logic [NUM_CH-1:0][7:0] d_v;
    logic [NUM_CH-1:0][3:0] aux_v;
    logic [NUM_CH-1:0][9:0] q_v;
    logic [NUM_CH-1:0][4:0] disp_v;

    assign mode_v = MODE;
    assign c_v    = C;
    assign d_v    = D;
    assign aux_v  = AUX;
    assign Q      = q_v;
    assign DISP   = disp_v;

    // Ones shift in behind reset; the top bit reaches Q_VALID as the first real symbol lands
    logic [STAGES:0] vld_pipe;

    always_ff @(posedge CK or negedge RESET) begin
        if (!RESET) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
    end

    assign Q_VALID = vld_pipe[STAGES];

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
            tmds_lane #(.EXTRA_PIPE(EXTRA_PIPE)) u_lane (
                .clk   (CK),
                .rst_n (RESET),
                .mode  (mode_v[i]),
                .c     (c_v[i]),
                .d     (d_v[i]),
                .aux   (aux_v[i]),
                .q     (q_v[i]),
                .disp  (disp_v[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_tmds_multich_encoder.sv
// Directed bench for tmds_multich_encoder: hand-computed symbol streams,
// plus a mixed-mode random run checked by decoding and disparity accounting.

module tb_tmds_multich_encoder;
    localparam int NCH = 3;
    localparam int XP  = 0;
    localparam int LAT = 2 + XP;
    localparam int NR  = 3000;
    localparam logic [9:0] CTRL0 = 10'b1101010100;

    logic                CK, RESET;
    logic [3*NCH-1:0]    MODE;
    logic [2*NCH-1:0]    C;
    logic [8*NCH-1:0]    D;
    logic [4*NCH-1:0]    AUX;
    logic [10*NCH-1:0]   Q;
    logic                Q_VALID;
    logic [5*NCH-1:0]    DISP;

    int n_chk  = 0;
    int n_fail = 0;

    tmds_multich_encoder #(.NUM_CH(NCH), .EXTRA_PIPE(XP)) dut (
        .CK      (CK),
        .RESET   (RESET),
        .MODE    (MODE),
        .C       (C),
        .D       (D),
        .AUX     (AUX),
        .Q       (Q),
        .Q_VALID (Q_VALID),
        .DISP    (DISP)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic all_ctrl();
        MODE = '0; C = '0; D = '0; AUX = '0;
    endtask

    task automatic drive(input int ch, input logic [2:0] m, input logic [1:0] c,
                         input logic [7:0] d, input logic [3:0] a);
        MODE[3*ch +: 3] = m;
        C[2*ch +: 2]    = c;
        D[8*ch +: 8]    = d;
        AUX[4*ch +: 4]  = a;
    endtask

    function automatic logic [9:0] terc(input logic [3:0] a);
        logic [9:0] s;
        case (a)
            4'h0: s = 10'b1010011100;  4'h1: s = 10'b1001100011;
            4'h2: s = 10'b1011100100;  4'h3: s = 10'b1011100010;
            4'h4: s = 10'b0101110001;  4'h5: s = 10'b0100011110;
            4'h6: s = 10'b0110001110;  4'h7: s = 10'b0100111100;
            4'h8: s = 10'b1011001100;  4'h9: s = 10'b0100111001;
            4'hA: s = 10'b0110011100;  4'hB: s = 10'b1011000110;
            4'hC: s = 10'b1010001110;  4'hD: s = 10'b1001110001;
            4'hE: s = 10'b0101100011;  default: s = 10'b1011000011;
        endcase
        return s;
    endfunction

    function automatic logic [9:0] ctrl(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00: s = 10'b1101010100;  2'b01: s = 10'b0010101011;
            2'b10: s = 10'b0101010100;  default: s = 10'b1010101011;
        endcase
        return s;
    endfunction

    // Inverse of the video coding, used to check random video symbols
    function automatic logic [7:0] dec(input logic [9:0] q);
        logic [7:0] t, r;
        t    = q[9] ? ~q[7:0] : q[7:0];
        r    = '0;
        r[0] = t[0];
        for (int k = 1; k < 8; k++) r[k] = q[8] ? (t[k] ^ t[k-1]) : ~(t[k] ^ t[k-1]);
        return r;
    endfunction

    // Single-channel stream table
    logic [2:0] sm [32];
    logic [1:0] sc [32];
    logic [7:0] sd [32];
    logic [3:0] sa [32];
    logic [9:0] sq [32];
    logic [4:0] sp [32];
    int ns = 0;

    task automatic sv(input logic [2:0] m, input logic [1:0] c, input logic [7:0] d,
                      input logic [3:0] a, input logic [9:0] q, input logic [4:0] p);
        sm[ns] = m; sc[ns] = c; sd[ns] = d; sa[ns] = a; sq[ns] = q; sp[ns] = p;
        ns++;
    endtask

    task automatic run_stream(input int ch, input string tag);
        int j;
        for (int i = 0; i < ns + LAT - 1; i++) begin
            all_ctrl();
            if (i < ns) drive(ch, sm[i], sc[i], sd[i], sa[i]);
            tick();
            if (i >= LAT - 1) begin
                j = i - LAT + 1;
                chk($sformatf("%s_q%0d", tag, j), 32'(Q[10*ch +: 10]), 32'(sq[j]));
                chk($sformatf("%s_disp%0d", tag, j), 32'(DISP[5*ch +: 5]), 32'(sp[j]));
                for (int k = 0; k < NCH; k++)
                    if (k != ch) chk($sformatf("%s_other%0d_ch%0d", tag, j, k),
                                     32'(Q[10*k +: 10]), 32'(CTRL0));
            end
        end
        ns = 0;
    endtask

    // Full-width stream table (all channels at once)
    logic [3*NCH-1:0]  fm [8];
    logic [8*NCH-1:0]  fd [8];
    logic [10*NCH-1:0] fq [8];
    logic [5*NCH-1:0]  fp [8];
    int nf = 0;

    task automatic fv(input logic [3*NCH-1:0] m, input logic [8*NCH-1:0] d,
                      input logic [10*NCH-1:0] q, input logic [5*NCH-1:0] p);
        fm[nf] = m; fd[nf] = d; fq[nf] = q; fp[nf] = p;
        nf++;
    endtask

    task automatic run_full(input string tag);
        int j;
        for (int i = 0; i < nf + LAT - 1; i++) begin
            all_ctrl();
            if (i < nf) begin MODE = fm[i]; D = fd[i]; end
            tick();
            if (i >= LAT - 1) begin
                j = i - LAT + 1;
                chk($sformatf("%s_q%0d", tag, j), 32'(Q), 32'(fq[j]));
                chk($sformatf("%s_disp%0d", tag, j), 32'(DISP), 32'(fp[j]));
            end
        end
        nf = 0;
    endtask

    logic [3*NCH-1:0] hm [NR];
    logic [2*NCH-1:0] hc [NR];
    logic [8*NCH-1:0] hd [NR];
    logic [4*NCH-1:0] ha [NR];

    task automatic run_random();
        int         exp_cnt [NCH];
        int         j, ds;
        logic [2:0] m;
        logic [9:0] qs, want;
        for (int k = 0; k < NCH; k++) exp_cnt[k] = 0;
        for (int i = 0; i < NR + LAT - 1; i++) begin
            all_ctrl();
            if (i < NR) begin
                for (int k = 0; k < NCH; k++) begin
                    m = ($urandom_range(0, 2) != 0) ? 3'd1 : 3'($urandom_range(0, 7));
                    drive(k, m, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                          4'($urandom_range(0, 15)));
                end
                hm[i] = MODE; hc[i] = C; hd[i] = D; ha[i] = AUX;
            end
            tick();
            if (i >= LAT - 1) begin
                j = i - LAT + 1;
                chk("rnd_valid", 32'(Q_VALID), 32'd1);
                for (int k = 0; k < NCH; k++) begin
                    m  = hm[j][3*k +: 3];
                    qs = Q[10*k +: 10];
                    ds = int'($signed(DISP[5*k +: 5]));
                    if (m == 3'd1) begin
                        exp_cnt[k] = exp_cnt[k] + 2 * $countones(qs) - 10;
                        chk($sformatf("rnd_dec_c%0d_%0d", k, j), 32'(dec(qs)), 32'(hd[j][8*k +: 8]));
                        chk($sformatf("rnd_disp_c%0d_%0d", k, j), 32'(DISP[5*k +: 5]),
                            32'(exp_cnt[k][4:0]));
                        chk($sformatf("rnd_bound_c%0d_%0d", k, j), 32'(ds >= -10 && ds <= 10), 32'd1);
                    end else begin
                        case (m)
                            3'd2:    want = terc(ha[j][4*k +: 4]);
                            3'd3:    want = 10'b0100110011;
                            3'd4:    want = 10'b1011001100;
                            default: want = ctrl(hc[j][2*k +: 2]);
                        endcase
                        exp_cnt[k] = 0;
                        chk($sformatf("rnd_sym_c%0d_%0d", k, j), 32'(qs), 32'(want));
                        chk($sformatf("rnd_zero_c%0d_%0d", k, j), 32'(DISP[5*k +: 5]), 32'd0);
                    end
                end
            end
        end
    endtask

    initial begin
        RESET = 1'b0;
        MODE = 9'($urandom); C = 6'($urandom); D = 24'($urandom); AUX = 12'($urandom);
        tick(); tick();
        MODE = 9'($urandom); D = 24'($urandom);
        tick();
        chk("rst_q", 32'(Q), 32'({NCH{CTRL0}}));
        chk("rst_disp", 32'(DISP), 32'd0);
        chk("rst_valid", 32'(Q_VALID), 32'd0);

        all_ctrl();
        RESET = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            chk($sformatf("rel_valid%0d", k), 32'(Q_VALID), 32'(k == LAT));
        end

        // ch0 D=00: all three video branches, then back to control
        sv(3'd1, 2'b00, 8'h00, 4'h0, 10'b0100000000, 5'h18);
        sv(3'd1, 2'b00, 8'h00, 4'h0, 10'b1111111111, 5'h02);
        sv(3'd1, 2'b00, 8'h00, 4'h0, 10'b0100000000, 5'h1A);
        sv(3'd0, 2'b00, 8'h00, 4'h0, CTRL0,          5'h00);
        run_stream(0, "v00");

        sv(3'd1, 2'b00, 8'hFF, 4'h0, 10'b1000000000, 5'h18);
        run_stream(1, "vff");

        // ch2: N1==4 tie-break both ways, then branches with q_m8=0
        sv(3'd1, 2'b00, 8'h1E, 4'h0, 10'b1001011111, 5'h04);
        sv(3'd1, 2'b00, 8'h0F, 4'h0, 10'b0100000101, 5'h00);
        sv(3'd1, 2'b00, 8'hFF, 4'h0, 10'b1000000000, 5'h18);
        sv(3'd1, 2'b00, 8'hFF, 4'h0, 10'b0011111111, 5'h1E);
        sv(3'd1, 2'b00, 8'hFF, 4'h0, 10'b0011111111, 5'h04);
        sv(3'd1, 2'b00, 8'hFF, 4'h0, 10'b1000000000, 5'h1C);
        sv(3'd6, 2'b00, 8'h00, 4'h0, CTRL0,          5'h00);
        run_stream(2, "tie");

        for (int a = 0; a < 16; a++) sv(3'd2, 2'b00, 8'h00, 4'(a), terc(4'(a)), 5'h00);
        run_stream(0, "terc");

        sv(3'd0, 2'b01, 8'h00, 4'h0, 10'b0010101011, 5'h00);
        sv(3'd0, 2'b10, 8'h00, 4'h0, 10'b0101010100, 5'h00);
        sv(3'd0, 2'b11, 8'h00, 4'h0, 10'b1010101011, 5'h00);
        sv(3'd5, 2'b01, 8'h00, 4'h0, 10'b0010101011, 5'h00);
        sv(3'd7, 2'b11, 8'h00, 4'h0, 10'b1010101011, 5'h00);
        sv(3'd6, 2'b00, 8'h00, 4'h0, 10'b1101010100, 5'h00);
        run_stream(1, "ctrl");

        // Guards interrupt video; the next video symbol restarts from cnt 0
        fv({3'd1, 3'd1, 3'd1}, 24'h0, {3{10'b0100000000}}, {3{5'h18}});
        fv({3'd3, 3'd3, 3'd4}, 24'h0, {10'b0100110011, 10'b0100110011, 10'b1011001100}, 15'h0);
        fv({3'd1, 3'd1, 3'd1}, 24'h0, {3{10'b0100000000}}, {3{5'h18}});
        fv({3'd0, 3'd0, 3'd0}, 24'h0, {3{CTRL0}}, 15'h0);
        run_full("guard");

        // Mid-stream asynchronous reset
        all_ctrl();
        MODE = {3'd1, 3'd1, 3'd1}; D = 24'h55AA33;
        tick(); tick(); tick();
        #2 RESET = 1'b0;
        #1;
        chk("mid_rst_q", 32'(Q), 32'({NCH{CTRL0}}));
        chk("mid_rst_disp", 32'(DISP), 32'd0);
        chk("mid_rst_valid", 32'(Q_VALID), 32'd0);
        @(posedge CK);
        #1;
        MODE = {3'd1, 3'd1, 3'd1}; D = 24'h0;
        RESET = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (k < LAT) begin
                chk($sformatf("post_rst_q%0d", k), 32'(Q), 32'({NCH{CTRL0}}));
                chk($sformatf("post_rst_valid%0d", k), 32'(Q_VALID), 32'd0);
            end else begin
                chk("post_rst_valid", 32'(Q_VALID), 32'd1);
                chk("post_rst_q", 32'(Q), 32'({3{10'b0100000000}}));
                chk("post_rst_disp", 32'(DISP), 32'({3{5'h18}}));
            end
        end
        all_ctrl();
        for (int k = 0; k < LAT; k++) tick();

        run_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
